wb_arbiter2: RTL

Two-master, one-slave Wishbone classic arbiter that shares a single slave (boot ROM or SRAM) between the CPU instruction bus (master 0) and the data/DMA bus (master 1). Grants are round-robin and held for a master's whole `cyc` window, so bursts and read-modify-write sequences stay atomic. The arbiter sits directly in front of the slave; the slave's own registered-ack behaviour is unchanged. An optional watchdog aborts transactions that the slave never acknowledges.

---
 rtl/wb_arbiter2_if.sv | 19 +
 rtl/wb_arbiter2.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2_if.sv
// Point-to-point Wishbone classic link used on every side of wb_arbiter2.
// err is raised only by the arbiter towards its masters; the shared slave has no error line.
interface wb_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter2.sv
// Round-robin two-master Wishbone classic arbiter holding each grant for the whole cyc window.
// Define WB_ARB_TIMEOUT_EN to build the watchdog that aborts beats the slave never acknowledges.
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_reset_ni,
    wb_arbiter2_if.slave  m0,
    wb_arbiter2_if.slave  m1,
    wb_arbiter2_if.master s
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
`ifdef WB_ARB_TIMEOUT_EN
        , ABORT
`endif
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   gnt0, gnt1;

    logic            cyc_mux, stb_mux, we_mux;
    logic [AW-1:0]   adr_mux;
    logic [DW-1:0]   dat_mux;
    logic [DW/8-1:0] sel_mux;

    // A grant only drives the slave while its owner still holds cyc, so the release cycle is quiet.
    assign gnt0 = (state_q == GRANT0) && m0.cyc;
    assign gnt1 = (state_q == GRANT1) && m1.cyc;

    always_comb begin
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        if (gnt0) begin
            cyc_mux = m0.cyc;
            stb_mux = m0.stb;
            we_mux  = m0.we;
            adr_mux = m0.adr;
            dat_mux = m0.dat_w;
            sel_mux = m0.sel;
        end else if (gnt1) begin
            cyc_mux = m1.cyc;
            stb_mux = m1.stb;
            we_mux  = m1.we;
            adr_mux = m1.adr;
            dat_mux = m1.dat_w;
            sel_mux = m1.sel;
        end
    end

    assign s.cyc   = cyc_mux;
    assign s.stb   = stb_mux;
    assign s.we    = we_mux;
    assign s.adr   = adr_mux;
    assign s.dat_w = dat_mux;
    assign s.sel   = sel_mux;

    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m0.ack   = gnt0 && s.ack;
    assign m1.ack   = gnt1 && s.ack;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int            WW      = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          stall, expire;

    assign stall  = stb_mux && !s.ack;
    assign expire = stall && (wdog_q == WD_LAST);

    // last already names the aborted master while in ABORT.
    assign m0.err = (state_q == ABORT) && !last_q;
    assign m1.err = (state_q == ABORT) && last_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);

    assign m0.err = 1'b0;
    assign m1.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
        wdog_d  = '0;
`endif
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc)
                    state_d = last_q ? GRANT0 : GRANT1;
                else if (m0.cyc)
                    state_d = GRANT0;
                else if (m1.cyc)
                    state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (!(gnt0 || gnt1)) begin
                    state_d = IDLE;
                    last_d  = (state_q == GRANT1);
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (expire) begin
                    state_d = ABORT;
                    last_d  = (state_q == GRANT1);
                end else if (stall) begin
                    wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
                end else if (!s.ack) begin
                    wdog_d = wdog_q;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

endmodule
